// File: rtl/pit_rw_control_if.sv
// -----------------------------------------------------------------------------
// pit_rw_control_if
// Bundles the CPU-side bus of the 8254 front end and the per-counter control
// signals it drives.
//   master : drives the CPU bus (cs_n, rd_n, wr_n, a, din), observes the rest
//   slave  : the front end; samples the CPU bus, drives dout and the
//            counter controls (ControlWord0/1/2, ChgControlWord,
//            EnableCounterLatch, EnableStatusLatch, WriteSignal, ReadSignal)
// -----------------------------------------------------------------------------
interface pit_rw_control_if #(
  parameter int NCNT = 3
);
  logic            cs_n;
  logic            rd_n;
  logic            wr_n;
  logic [1:0]      a;
  logic [7:0]      din;
  logic [7:0]      dout;
  logic [5:0]      ControlWord0;
  logic [5:0]      ControlWord1;
  logic [5:0]      ControlWord2;
  logic [NCNT-1:0] ChgControlWord;
  logic [NCNT-1:0] EnableCounterLatch;
  logic [NCNT-1:0] EnableStatusLatch;
  logic [NCNT-1:0] WriteSignal;
  logic [NCNT-1:0] ReadSignal;

  modport master (
    output cs_n, rd_n, wr_n, a, din,
    input  dout, ControlWord0, ControlWord1, ControlWord2,
           ChgControlWord, EnableCounterLatch, EnableStatusLatch,
           WriteSignal, ReadSignal
  );

  modport slave (
    input  cs_n, rd_n, wr_n, a, din,
    output dout, ControlWord0, ControlWord1, ControlWord2,
           ChgControlWord, EnableCounterLatch, EnableStatusLatch,
           WriteSignal, ReadSignal
  );
endinterface

// File: rtl/pit_rw_control.sv
// -----------------------------------------------------------------------------
// pit_rw_control
// Bus interface and control-word decoder for the 8254 timer. Registers the CPU
// bus, detects the falling edge of wr_n, and decodes data writes, mode words,
// counter-latch and read-back commands into per-counter control pulses.
// Ports:
//   clkinput : rising-edge system clock
//   reset    : synchronous, active-high
//   bus      : pit_rw_control_if.slave (CPU bus in, counter controls out)
// All outputs are registered; pulses last exactly one clock.
// -----------------------------------------------------------------------------
module pit_rw_control #(
  parameter int NCNT = 3
) (
  input  logic clkinput,
  input  logic reset,
  pit_rw_control_if.slave bus
);

  // S1: raw bus sample; S2: previous wr_n for falling-edge detection
  logic            s1_cs_n, s1_rd_n, s1_wr_n;
  logic [1:0]      s1_a;
  logic [7:0]      s1_din;
  logic            s2_wr_n;

  logic [7:0]      dout_q;
  logic [5:0]      cw_q [NCNT];
  logic [NCNT-1:0] chg_q, ecl_q, esl_q, ws_q, rs_q;

  // One command per strobe: only the cycle where wr_n has just gone low counts.
  // A rising cs_n with wr_n still low leaves s2_wr_n at 0, so nothing re-fires.
  logic wr_accept;
  logic rd_active;
  logic [1:0] sc;

  assign wr_accept = !s1_cs_n && !s1_wr_n && s1_rd_n && s2_wr_n;
  assign rd_active = !s1_cs_n && !s1_rd_n && s1_wr_n;
  assign sc        = s1_din[7:6];

  always_ff @(posedge clkinput) begin
    // NOTE: non-blocking assignments everywhere here, so every register sees
    // the pre-edge value of its sources regardless of statement order.
    if (reset) begin
      s1_cs_n <= 1'b1;
      s1_rd_n <= 1'b1;
      s1_wr_n <= 1'b1;
      s1_a    <= '0;
      s1_din  <= '0;
      s2_wr_n <= 1'b1;
      dout_q  <= '0;
      // NOTE: the control-word array is only three registers and its reset
      // value is architecturally visible, so it is reset like any flop.
      for (int i = 0; i < NCNT; i++) cw_q[i] <= '0;
      chg_q   <= '0;
      ecl_q   <= '0;
      esl_q   <= '0;
      ws_q    <= '0;
      rs_q    <= '0;
    end else begin
      s1_cs_n <= bus.cs_n;
      s1_rd_n <= bus.rd_n;
      s1_wr_n <= bus.wr_n;
      s1_a    <= bus.a;
      s1_din  <= bus.din;
      s2_wr_n <= s1_wr_n;

      // Pulses default low so they can never stretch past one cycle.
      chg_q <= '0;
      ecl_q <= '0;
      esl_q <= '0;
      ws_q  <= '0;

      for (int i = 0; i < NCNT; i++) begin
        rs_q[i] <= rd_active && (int'(s1_a) == i);
      end

      if (wr_accept) begin
        if (s1_a != 2'd3) begin
          dout_q <= s1_din;
          for (int i = 0; i < NCNT; i++) begin
            if (int'(s1_a) == i) ws_q[i] <= 1'b1;
          end
        end else if (sc == 2'd3) begin
          // Read-back: COUNT/STATUS bits are active-low; din[3:1] select counters.
          for (int i = 0; i < NCNT; i++) begin
            if (s1_din[1+i]) begin
              ecl_q[i] <= !s1_din[5];
              esl_q[i] <= !s1_din[4];
            end
          end
        end else begin
          for (int i = 0; i < NCNT; i++) begin
            if (int'(sc) == i) begin
              if (s1_din[5:4] == 2'b00) begin
                ecl_q[i] <= 1'b1;
              end else begin
                cw_q[i]  <= s1_din[5:0];
                chg_q[i] <= 1'b1;
              end
            end
          end
        end
      end
    end
  end

  assign bus.dout               = dout_q;
  assign bus.ControlWord0       = cw_q[0];
  assign bus.ControlWord1       = cw_q[1];
  assign bus.ControlWord2       = cw_q[2];
  assign bus.ChgControlWord     = chg_q;
  assign bus.EnableCounterLatch = ecl_q;
  assign bus.EnableStatusLatch  = esl_q;
  assign bus.WriteSignal        = ws_q;
  assign bus.ReadSignal         = rs_q;

endmodule

// File: tb/tb_pit_rw_control.sv
// -----------------------------------------------------------------------------
// tb_pit_rw_control
// Directed self-checking bench for pit_rw_control. Inputs change 1 time unit
// after a rising edge and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_pit_rw_control;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  pit_rw_control_if bus ();

  pit_rw_control #(.NCNT(3)) dut (
    .clkinput (clk),
    .reset    (reset),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.cs_n = 1'b1;
    bus.rd_n = 1'b1;
    bus.wr_n = 1'b1;
  endtask

  // Single-cycle write strobe; returns just after E1 (decoded outputs visible).
  task automatic do_write(input logic [1:0] addr, input logic [7:0] data);
    bus.a    = addr;
    bus.din  = data;
    bus.cs_n = 1'b0;
    bus.wr_n = 1'b0;
    tick();
    idle();
    tick();
  endtask

  // {Chg, ECL, ESL, WS}
  function automatic logic [11:0] pulses();
    return {bus.ChgControlWord, bus.EnableCounterLatch,
            bus.EnableStatusLatch, bus.WriteSignal};
  endfunction

  initial begin
    reset    = 1'b1;
    bus.cs_n = 1'b1;
    bus.rd_n = 1'b1;
    bus.wr_n = 1'b1;
    bus.a    = 2'd0;
    bus.din  = 8'h00;

    // Reset with random bus activity
    for (int i = 0; i < 2; i++) begin
      bus.cs_n = 1'($urandom_range(0, 1));
      bus.rd_n = 1'($urandom_range(0, 1));
      bus.wr_n = 1'($urandom_range(0, 1));
      bus.a    = 2'($urandom_range(0, 3));
      bus.din  = 8'($urandom_range(0, 255));
      tick();
    end
    check("reset_dout",   32'(bus.dout), 32'h00);
    check("reset_cw",     32'({bus.ControlWord0, bus.ControlWord1, bus.ControlWord2}), 32'h0);
    check("reset_pulses", 32'(pulses()), 32'h0);
    check("reset_rs",     32'(bus.ReadSignal), 32'h0);
    reset = 1'b0;
    idle();
    tick();
    tick();
    check("idle_pulses", 32'(pulses()), 32'h0);

    // Mode word to counter 1, wr_n low for 3 sampled edges
    bus.a = 2'd3; bus.din = 8'h53; bus.cs_n = 1'b0; bus.wr_n = 1'b0;
    tick();
    check("mode_e0_chg", 32'(bus.ChgControlWord), 32'h0);
    tick();
    check("mode_e1_chg", 32'(bus.ChgControlWord), 32'b010);
    check("mode_e1_cw1", 32'(bus.ControlWord1), 32'b010011);
    check("mode_e1_cw0", 32'(bus.ControlWord0), 32'h0);
    check("mode_e1_cw2", 32'(bus.ControlWord2), 32'h0);
    tick();
    check("mode_e2_chg_once", 32'(pulses()), 32'h0);
    idle();
    tick();
    check("mode_hold_chg", 32'(pulses()), 32'h0);
    check("mode_hold_cw1", 32'(bus.ControlWord1), 32'b010011);

    // Mode word to counter 0: SC=0 RW=11 M=010 BCD=0
    do_write(2'd3, 8'h34);
    check("mode0_chg", 32'(bus.ChgControlWord), 32'b001);
    check("mode0_cw0", 32'(bus.ControlWord0), 32'b110100);
    check("mode0_cw1", 32'(bus.ControlWord1), 32'b010011);
    tick();

    // Data writes to counter 1
    do_write(2'd1, 8'd16);
    check("data1_ws",   32'(bus.WriteSignal), 32'b010);
    check("data1_dout", 32'(bus.dout), 32'd16);
    tick();
    check("data1_ws_off", 32'(bus.WriteSignal), 32'h0);
    check("data1_hold",   32'(bus.dout), 32'd16);
    do_write(2'd1, 8'd0);
    check("data2_ws",   32'(bus.WriteSignal), 32'b010);
    check("data2_dout", 32'(bus.dout), 32'd0);
    tick();

    // Counter-latch command for counter 1
    do_write(2'd3, 8'h40);
    check("latch_pulses", 32'(pulses()), 32'({3'b000, 3'b010, 3'b000, 3'b000}));
    check("latch_cw1",    32'(bus.ControlWord1), 32'b010011);
    tick();
    check("latch_off", 32'(pulses()), 32'h0);

    // Read-back: count+status for counters 0 and 2
    do_write(2'd3, 8'hCA);
    check("rb1_pulses", 32'(pulses()), 32'({3'b000, 3'b101, 3'b101, 3'b000}));
    check("rb1_cw", 32'({bus.ControlWord0, bus.ControlWord1, bus.ControlWord2}),
          32'({6'b110100, 6'b010011, 6'b000000}));
    tick();
    // Read-back: count only for counter 1
    do_write(2'd3, 8'hD4);
    check("rb2_pulses", 32'(pulses()), 32'({3'b000, 3'b010, 3'b000, 3'b000}));
    tick();
    check("rb2_off", 32'(pulses()), 32'h0);

    // Read strobe on counter 1, rd_n low for 5 sampled edges
    bus.a = 2'd1; bus.cs_n = 1'b0; bus.rd_n = 1'b0;
    tick();
    check("rd_e0", 32'(bus.ReadSignal), 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rd_active", 32'(bus.ReadSignal), 32'b010);
    end
    idle();
    tick();
    check("rd_tail", 32'(bus.ReadSignal), 32'b010);
    tick();
    check("rd_off", 32'(bus.ReadSignal), 32'h0);

    // rd_n and wr_n both low: nothing happens
    bus.a = 2'd1; bus.din = 8'h99; bus.cs_n = 1'b0; bus.rd_n = 1'b0; bus.wr_n = 1'b0;
    tick();
    tick();
    check("both_rs",     32'(bus.ReadSignal), 32'h0);
    check("both_pulses", 32'(pulses()), 32'h0);
    // Releasing rd_n while wr_n stays low is not a new falling edge
    bus.rd_n = 1'b1;
    tick();
    tick();
    check("both_release_pulses", 32'(pulses()), 32'h0);
    check("both_dout", 32'(bus.dout), 32'd0);
    idle();
    tick();

    // cs_n bounce while wr_n held low: exactly one write
    bus.a = 2'd2; bus.din = 8'h77; bus.cs_n = 1'b0; bus.wr_n = 1'b0;
    tick();
    tick();
    check("csb_ws",   32'(bus.WriteSignal), 32'b100);
    check("csb_dout", 32'(bus.dout), 32'h77);
    bus.cs_n = 1'b1;
    tick();
    bus.cs_n = 1'b0;
    tick();
    tick();
    check("csb_no_refire", 32'(pulses()), 32'h0);
    idle();
    tick();

    // Read of the control address asserts nothing
    bus.a = 2'd3; bus.cs_n = 1'b0; bus.rd_n = 1'b0;
    tick();
    tick();
    check("rd_ctrl_rs", 32'(bus.ReadSignal), 32'h0);
    idle();
    tick();

    // Reset mid-write; S2 returns to 1 so the still-low wr_n counts afresh
    bus.a = 2'd0; bus.din = 8'hAA; bus.cs_n = 1'b0; bus.wr_n = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("mid_reset_pulses", 32'(pulses()), 32'h0);
    check("mid_reset_cw", 32'({bus.ControlWord0, bus.ControlWord1, bus.ControlWord2}), 32'h0);
    check("mid_reset_dout", 32'(bus.dout), 32'h0);
    reset = 1'b0;
    tick();
    check("post_reset_e0", 32'(pulses()), 32'h0);
    tick();
    check("post_reset_ws",   32'(bus.WriteSignal), 32'b001);
    check("post_reset_dout", 32'(bus.dout), 32'hAA);
    idle();
    tick();
    check("post_reset_off", 32'(pulses()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
